// File: rtl/gf_mult_2_10.sv
// GF(2^10) polynomial-basis multiplier modulo p(x) = x^10 + x^3 + 1.
// Combinational by default; define GF_MULT_2_10_OUT_REG_EN for one output register stage.
module gf_mult_2_10 #(
  parameter int GF_LEN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GF_LEN-1:0] a,
  input  logic [GF_LEN-1:0] b,
  input  logic              in_valid,
  output logic [GF_LEN-1:0] out,
  output logic              out_valid
);

  localparam int PROD_W = 2 * GF_LEN - 1;

  // The reduction below hard-wires x^10 = x^3 + 1, so no other width is meaningful.
  generate
    if (GF_LEN != 10) begin : g_bad_len
      $error("gf_mult_2_10: GF_LEN must be 10, got %0d", GF_LEN);
    end
  endgenerate

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] fold;
  logic [GF_LEN-1:0] red;

  // Carry-less product followed by a high-to-low fold; all indices are constant,
  // so this elaborates into a fixed AND/XOR network.
  always_comb begin
    prod = '0;
    for (int i = 0; i < GF_LEN; i++) begin
      for (int j = 0; j < GF_LEN; j++) begin
        prod[i+j] = prod[i+j] ^ (a[i] & b[j]);
      end
    end
    fold = prod;
    for (int k = PROD_W - 1; k >= GF_LEN; k--) begin
      fold[k-GF_LEN]     = fold[k-GF_LEN] ^ fold[k];
      fold[k-GF_LEN+3]   = fold[k-GF_LEN+3] ^ fold[k];
      fold[k]            = 1'b0;
    end
    red = fold[GF_LEN-1:0];
  end

`ifdef GF_MULT_2_10_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= red;
      end
    end
  end
`else
  // clk and rst have no role in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign out       = red;
  assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_gf_mult_2_10.sv
// Self-checking bench for gf_mult_2_10: directed vectors, reference-model sweep,
// and (when GF_MULT_2_10_OUT_REG_EN is defined) the register-stage timing.
module tb_gf_mult_2_10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] a = '0;
  logic [9:0] b = '0;
  logic       in_valid = 1'b0;
  logic [9:0] out;
  logic       out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp_q[$];

  gf_mult_2_10 #(.GF_LEN(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent shift-and-reduce model: multiply a by x step by step.
  function automatic logic [9:0] ref_mul(input logic [9:0] x, input logic [9:0] y);
    logic [10:0] acc;
    logic [9:0]  r;
    acc = {1'b0, x};
    r   = '0;
    for (int i = 0; i < 10; i++) begin
      if (y[i]) r = r ^ acc[9:0];
      acc = acc << 1;
      if (acc[10]) acc = acc ^ 11'h409;
    end
    return r;
  endfunction

  task automatic apply(input logic [9:0] x, input logic [9:0] y, output logic [9:0] res);
    a        = x;
    b        = y;
    in_valid = 1'b1;
`ifdef GF_MULT_2_10_OUT_REG_EN
    @(posedge clk);
`endif
    #1;
    res = out;
  endtask

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] p;
  } vec_t;

  vec_t vecs[13] = '{
    '{10'h3FF, 10'h001, 10'h3FF},
    '{10'h2A5, 10'h000, 10'h000},
    '{10'h000, 10'h3FF, 10'h000},
    '{10'h200, 10'h002, 10'h009},
    '{10'h200, 10'h200, 10'h112},
    '{10'h002, 10'h204, 10'h001},
    '{10'h204, 10'h002, 10'h001},
    '{10'h001, 10'h001, 10'h001},
    '{10'h100, 10'h004, 10'h009},
    '{10'h004, 10'h100, 10'h009},
    '{10'h003, 10'h003, 10'h005},
    '{10'h020, 10'h040, 10'h012},
    '{10'h3FF, 10'h002, 10'h3F7}
  };

  initial begin
    logic [9:0] r0, r1, r2, ex;
    logic [9:0] x, y, z;

`ifdef GF_MULT_2_10_OUT_REG_EN
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 10'h200;
    b        = 10'h200;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_out", out, 10'h000);
      check("reset_valid", out_valid, 1'b0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_out", out, 10'h112);
    check("first_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    a        = 10'h3FF;
    b        = 10'h001;
    @(posedge clk);
    #1;
    check("idle_valid", out_valid, 1'b0);
    check("idle_hold", out, 10'h112);
`else
    rst = 1'b0;
    #1;
    check("comb_valid_low", out_valid, 1'b0);
    in_valid = 1'b1;
    #1;
    check("comb_valid_high", out_valid, 1'b1);
`endif

    foreach (vecs[i]) exp_q.push_back(vecs[i].p);
    foreach (vecs[i]) begin
      apply(vecs[i].x, vecs[i].y, r0);
      ex = exp_q.pop_front();
      check($sformatf("vec%0d", i), r0, ex);
    end
    check("valid_during_vecs", out_valid, 1'b1);

    for (int n = 0; n < 2000; n++) begin
      x = 10'($urandom_range(0, 1023));
      y = 10'($urandom_range(0, 1023));
      z = 10'($urandom_range(0, 1023));
      apply(x, y, r0);
      check("rand_model", r0, ref_mul(x, y));
      apply(y, x, r1);
      check("rand_commute", r1, r0);
      apply(x, z, r2);
      apply(x, y ^ z, r1);
      check("rand_distrib", r1, r0 ^ r2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
